// File: rtl/vga_timing_pkg.sv
// Shared timing definitions for the VGA raster generator.
//   axis_state_t : region of one raster axis (active, front porch, sync, back porch)
//   DEF_*        : default 640x480 @ 60 Hz timing (25 MHz pixel strobe)
//   DEF_CNT_W    : position counter width able to hold 799 and 524
//   axis_total() : total length of an axis from its four region lengths
package vga_timing_pkg;

    typedef enum logic [1:0] {
        ACT = 2'd0,
        FP  = 2'd1,
        SY  = 2'd2,
        BP  = 2'd3
    } axis_state_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;
    localparam int DEF_CNT_W    = 10;

    function automatic int axis_total(input int active, input int front,
                                      input int sync, input int back);
        return active + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_sync_controller_axis.sv
// One raster axis: position counter, four-region FSM and registered sync level.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   step         : advance the axis by one position this clk
//   count        : current position, 0..TOTAL-1 (registered)
//   sync         : SYNC_ACTIVE while the axis is in the sync region (registered)
//   wrap         : current position is the last one (TOTAL-1)
//   active_next  : the axis will be in its active region after this clk edge,
//                  so the parent can register a level aligned with count
module sync_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   ACTIVE      = DEF_H_ACTIVE,
    parameter int   FRONT       = DEF_H_FRONT,
    parameter int   SYNC        = DEF_H_SYNC,
    parameter int   BACK        = DEF_H_BACK,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output logic             sync,
    output logic             wrap,
    output logic             active_next
);

    localparam int TOTAL = axis_total(ACTIVE, FRONT, SYNC, BACK);

    // Last position of each region; the FSM leaves a region on the step taken there.
    localparam logic [CNT_W-1:0] LAST_ACT = CNT_W'(ACTIVE - 1);
    localparam logic [CNT_W-1:0] LAST_FP  = CNT_W'(ACTIVE + FRONT - 1);
    localparam logic [CNT_W-1:0] LAST_SY  = CNT_W'(ACTIVE + FRONT + SYNC - 1);
    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(TOTAL - 1);

    axis_state_t      state, state_next;
    logic [CNT_W-1:0] count_next;
    logic             sync_next;

    assign wrap = (count == LAST_POS);

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            ACT: if (step && count == LAST_ACT) state_next = FP;
            FP:  if (step && count == LAST_FP)  state_next = SY;
            SY:  if (step && count == LAST_SY)  state_next = BP;
            BP:  if (step && wrap)              state_next = ACT;
            default: state_next = BP;
        endcase
        if (step) begin
            count_next = wrap ? '0 : count + 1'b1;
        end
        sync_next   = (state_next == SY) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        active_next = (state_next == ACT);
    end

    // Reset parks the axis on its last back-porch position so the first step lands on 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BP;
            count <= LAST_POS;
            sync  <= ~SYNC_ACTIVE;
        end else begin
            state <= state_next;
            count <= count_next;
            sync  <= sync_next;
        end
    end

endmodule

// File: rtl/vga_sync_controller.sv
// VGA raster sequencer. Advances the horizontal position on every pixel strobe
// and the vertical position on the strobe that wraps a line.
// Ports:
//   clk, rst     : system clock, synchronous active-high reset (wins over pixel_en)
//   pixel_en     : one-clk pixel strobe
//   pixel_x/y    : current raster position
//   video_on     : position is inside the visible area
//   hsync/vsync  : sync levels, SYNC_ACTIVE during the sync regions
//   line_start   : one-clk pulse when pixel_x has just become 0
//   frame_start  : one-clk pulse when (pixel_x, pixel_y) has just become (0,0)
// Every output is a flop; pixel_en only reaches flop inputs.
module vga_sync_controller
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE    = DEF_H_ACTIVE,
    parameter int   H_FRONT     = DEF_H_FRONT,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BACK      = DEF_H_BACK,
    parameter int   V_ACTIVE    = DEF_V_ACTIVE,
    parameter int   V_FRONT     = DEF_V_FRONT,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BACK      = DEF_V_BACK,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pixel_en,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             video_on,
    output logic             hsync,
    output logic             vsync,
    output logic             line_start,
    output logic             frame_start
);

    logic h_wrap, v_wrap;
    logic h_active_next, v_active_next;
    logic v_step;

    // The vertical axis only moves on the strobe that ends a line.
    assign v_step = pixel_en & h_wrap;

    sync_axis_counter #(
        .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
        .SYNC_ACTIVE(SYNC_ACTIVE), .CNT_W(CNT_W)
    ) u_h_axis (
        .clk(clk), .rst(rst), .step(pixel_en),
        .count(pixel_x), .sync(hsync), .wrap(h_wrap), .active_next(h_active_next)
    );

    sync_axis_counter #(
        .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
        .SYNC_ACTIVE(SYNC_ACTIVE), .CNT_W(CNT_W)
    ) u_v_axis (
        .clk(clk), .rst(rst), .step(v_step),
        .count(pixel_y), .sync(vsync), .wrap(v_wrap), .active_next(v_active_next)
    );

    // Pulses are raised on the edge that moves the counters to 0, so they sit
    // alongside the new position for exactly one clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            video_on    <= h_active_next & v_active_next;
            line_start  <= v_step;
            frame_start <= v_step & v_wrap;
        end
    end

endmodule
